// File: rtl/boot_loader.sv
// Framed byte-stream image loader: packs little-endian bytes into 32-bit words,
// writes them to consecutive word addresses and releases the core on a good XOR checksum.
module boot_loader #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int unsigned       MAX_WORDS  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int unsigned WIDX_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [WIDX_W-1:0] word_idx_q, word_idx_d;
  logic [WIDX_W-1:0] word_idx_inc;

  logic              byte_ready_q, byte_ready_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic accept;

  assign accept       = byte_valid && byte_ready_q;
  assign word_idx_inc = word_idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    csum_d      = csum_q;
    word_idx_d  = word_idx_q;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_LO;
          csum_d     = '0;
          word_idx_d = '0;
          byte_idx_d = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = byte_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = {byte_data, len_lo_q};
          if (32'(len_d) > MAX_WORDS) begin
            state_d = S_ERR;
          end else if (len_d == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          // Shift in from the top so byte 0 lands in [7:0] after four accepts.
          word_d     = {byte_data, word_q[31:8]};
          csum_d     = csum_q ^ byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d     = S_WRITE;
            mem_write_d = 1'b1;
            mem_addr_d  = START_ADDR + ADDR_W'(word_idx_q);
            mem_wdata_d = word_d;
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_inc;
        state_d    = (32'(word_idx_inc) == 32'(len_q)) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (accept) begin
          state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are a registered image of the next state.
    byte_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                   (state_d == S_DATA)   || (state_d == S_CHECK);
    busy_d       = byte_ready_d || (state_d == S_WRITE);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
    core_rst_n_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      word_idx_q   <= '0;
      byte_ready_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= START_ADDR;
      mem_wdata_q  <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      word_idx_q   <= word_idx_d;
      byte_ready_q <= byte_ready_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: driver pushes expected writes/results from a frame-level
// model, a negedge monitor pops and compares whenever the DUT writes or reports a result.
module tb_boot_loader;
  localparam int unsigned MAXW = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        error;

  boot_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          ok;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] frame_q[$];
  int         checks   = 0;
  int         failures = 0;
  bit         prev_res = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Monitor: compares DUT output events against the scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    bit   res;
    if (rst) begin
      if (mem_write) begin
        chk("ready_in_write", byte_ready, 0);
        if (exp_q.size() == 0 || !exp_q[0].is_wr) begin
          checks++; failures++;
          $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
          $display("write addr=%h data=%h", mem_addr, mem_wdata);
        end
      end
      res = done | error;
      if (res && !prev_res) begin
        if (exp_q.size() == 0 || exp_q[0].is_wr) begin
          checks++; failures++;
          $display("FAIL unexpected_result done=%0b error=%0b", done, error);
        end else begin
          e = exp_q.pop_front();
          chk("res_done", done, e.ok);
          chk("res_error", error, !e.ok);
          chk("res_core_rst_n", core_rst_n, e.ok);
          $display("result done=%0b error=%0b core_rst_n=%0b", done, error, core_rst_n);
        end
      end
      prev_res = res;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int waitc = 0;
    if (toggle) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (1) begin
      @(negedge clk);
      if (byte_ready) break;
      waitc++;
      if (waitc > 100) begin
        checks++; failures++;
        $display("FAIL byte_accept_timeout byte=%h ready=%0b expected ready=1", b, byte_ready);
        break;
      end
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", error, 0);
    chk("start_core_rst", core_rst_n, 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drain", exp_q.size(), 0);
  endtask

  task automatic build_frame(input logic [15:0] n, input bit good);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    frame_q = {};
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    if (32'(n) <= MAXW) begin
      for (int i = 0; i < 4 * int'(n); i++) begin
        b = 8'($urandom);
        x ^= b;
        frame_q.push_back(b);
      end
      frame_q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    end
  endtask

  // Frame-level reference: decode N, list the expected word writes, then the verdict.
  task automatic run_frame(input bit toggle);
    int          n;
    int          nbytes;
    logic [7:0]  x = 8'h00;
    bit          ok;
    exp_t        e;
    n = int'({frame_q[1], frame_q[0]});
    if (n > int'(MAXW)) begin
      ok = 1'b0;
      nbytes = 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        e.is_wr = 1'b1;
        e.addr  = 32'(i);
        e.data  = {frame_q[5+4*i], frame_q[4+4*i], frame_q[3+4*i], frame_q[2+4*i]};
        e.ok    = 1'b0;
        exp_q.push_back(e);
      end
      for (int j = 2; j < 2 + 4 * n; j++) x ^= frame_q[j];
      ok = (frame_q[2+4*n] == x);
      nbytes = 3 + 4 * n;
    end
    e.is_wr = 1'b0; e.addr = '0; e.data = '0; e.ok = ok;
    exp_q.push_back(e);
    do_start();
    for (int j = 0; j < nbytes; j++) begin
      send_byte(frame_q[j], toggle);
      if (j >= 2 && j < nbytes - 1 && ((j - 2) % 4) == 3) chk("write_latency", mem_write, 1);
    end
    if (n > int'(MAXW)) begin
      chk("oversize_error", error, 1);
      chk("oversize_ready", byte_ready, 0);
      chk("oversize_busy", busy, 0);
    end else begin
      chk("final_done", done, ok);
      chk("final_error", error, !ok);
      chk("final_core_rst_n", core_rst_n, ok);
    end
    wait_drain();
    $display("frame n=%0d toggle=%0b expect_ok=%0b", n, toggle, ok);
  endtask

  task automatic set_test1_frame();
    frame_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
  endtask

  task automatic check_reset_outputs();
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    #12;
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", byte_ready, 0);

    set_test1_frame();
    run_frame(1'b0);
    set_test1_frame();
    frame_q[10] = 8'h45;
    run_frame(1'b0);
    frame_q = '{8'h00, 8'h00, 8'h00};
    run_frame(1'b0);
    frame_q = '{8'h01, 8'h01};
    run_frame(1'b0);
    set_test1_frame();
    run_frame(1'b1);

    // Reset in the middle of a load: first word already written, fifth payload byte taken.
    set_test1_frame();
    e.is_wr = 1'b1; e.addr = 32'h0; e.data = 32'h44332211; e.ok = 1'b0;
    exp_q.push_back(e);
    do_start();
    for (int j = 0; j < 7; j++) send_byte(frame_q[j], 1'b0);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    chk("rst_scoreboard", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    set_test1_frame();
    run_frame(1'b0);

    build_frame(16'd256, 1'b1);
    run_frame(1'b0);
    build_frame(16'hFFFF, 1'b1);
    run_frame(1'b0);

    for (int k = 0; k < 14; k++) begin
      logic [15:0] n;
      n = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(257, 600)) : 16'($urandom_range(0, 6));
      build_frame(n, $urandom_range(0, 3) != 0);
      run_frame(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
